// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Merges single-cycle ALU writebacks (source A) with long-latency
// load/mul/div writebacks (source B) onto one registered write port.
// B results wait in a small FIFO. An accepted A write to a register kills
// any older queued B write to that register, so per-register ordering holds.
// A starvation counter periodically forces the B head through.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [ADDR_W-1:0]           a_addr,
    input  logic [DATA_W-1:0]           a_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [ADDR_W-1:0]           b_addr,
    input  logic [DATA_W-1:0]           b_data,
    output logic                        wb_regwrite,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic [DATA_W-1:0]           wb_data,
    output logic [(2**ADDR_W)-1:0]      pending_mask,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [QDEPTH-1:0] slot_valid;
    logic [ADDR_W-1:0] slot_addr [QDEPTH];
    logic [DATA_W-1:0] slot_data [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [SC_W-1:0]   starve_cnt;

    logic q_empty;
    logic q_full;
    logic head_valid;
    logic force_b;
    logic a_write;
    logic pop;
    logic pop_write;
    logic push;

    assign q_empty    = (count == '0);
    assign q_full     = (count == CNT_W'(QDEPTH));
    assign head_valid = !q_empty && slot_valid[rd_ptr];
    assign force_b    = (starve_cnt == SC_W'(STARVE_MAX)) && head_valid;

    assign a_ready = !force_b;
    // Depends only on registered occupancy: a same-cycle pop never frees room.
    assign b_ready = !q_full;

    // Address 0 is hard-wired, so requests to it are accepted but never write.
    assign a_write   = a_valid && a_ready && (a_addr != '0);
    // A killed head always leaves; a live head leaves only when A is not writing.
    assign pop       = !q_empty && (!slot_valid[rd_ptr] || !a_write);
    assign pop_write = pop && slot_valid[rd_ptr];
    // A same-cycle A write to the same register is younger, so the B write is dropped.
    assign push      = b_valid && b_ready && (b_addr != '0) &&
                       !(a_write && (b_addr == a_addr));

    assign q_count = count;

    // Pending mask: one bit per register targeted by a live queued slot.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        pending_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (slot_valid[i]) pending_mask[slot_addr[i]] = 1'b1;
        end
    end

    // Queue control: valid bits, pointers, occupancy and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments, so later writes to the same bit in this
            // block win and every read above sees the pre-edge state.
            for (int i = 0; i < QDEPTH; i++) begin
                if (a_write && slot_valid[i] && (slot_addr[i] == a_addr))
                    slot_valid[i] <= 1'b0;
            end
            if (pop) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (head_valid && !pop)
                starve_cnt <= (starve_cnt == SC_W'(STARVE_MAX)) ? starve_cnt
                                                                : starve_cnt + SC_W'(1);
            else
                starve_cnt <= '0;
        end
    end

    // Queue payload storage: written on push only.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset; a slot is only ever read while its valid bit is set.
        if (push) begin
            slot_addr[wr_ptr] <= b_addr;
            slot_data[wr_ptr] <= b_data;
        end
    end

    // Registered write port: A first, then the live queue head, else idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_regwrite <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
        end else if (a_write) begin
            wb_regwrite <= 1'b1;
            wb_addr     <= a_addr;
            wb_data     <= a_data;
        end else if (pop_write) begin
            wb_regwrite <= 1'b1;
            wb_addr     <= slot_addr[rd_ptr];
            wb_data     <= slot_data[rd_ptr];
        end else begin
            wb_regwrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// A queue-of-entries model predicts every output each cycle. Directed
// scenarios are followed by a randomized run.
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int QDEPTH     = 4;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = $clog2(QDEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              wb_regwrite;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       pending_mask;
    logic [CNT_W-1:0]  q_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending_mask(pending_mask), .q_count(q_count)
    );

    typedef struct {
        bit                v;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    // Reference model state
    entry_t            mq[$];
    int                starve;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    wr_t wr_log[$];
    int  aready_low;
    int  max_qc;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        starve = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock cycle: drive inputs at negedge, check combinational outputs,
    // advance the model, then check the registered port after the posedge.
    task automatic cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        bit          head_v, force_b, a_wr, do_pop, exp_br;
        logic [31:0] mask;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        head_v  = (mq.size() > 0) && mq[0].v;
        force_b = (starve == STARVE_MAX) && head_v;
        exp_br  = (mq.size() < QDEPTH);
        mask = '0;
        foreach (mq[i]) if (mq[i].v) mask[mq[i].addr] = 1'b1;
        check("a_ready", 64'(a_ready), 64'(!force_b));
        check("b_ready", 64'(b_ready), 64'(exp_br));
        check("pending_mask", 64'(pending_mask), 64'(mask));
        check("q_count", 64'(q_count), 64'(mq.size()));
        if (!a_ready) aready_low++;
        if (int'(q_count) > max_qc) max_qc = int'(q_count);

        a_wr   = av && !force_b && (aa != '0);
        do_pop = (mq.size() > 0) && (!mq[0].v || !a_wr);
        if (a_wr) begin
            m_we = 1'b1; m_addr = aa; m_data = ad;
        end else if (head_v) begin
            m_we = 1'b1; m_addr = mq[0].addr; m_data = mq[0].data;
        end else begin
            m_we = 1'b0;
        end
        if (head_v && !do_pop) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        else                   starve = 0;
        if (a_wr) foreach (mq[i]) if (mq[i].addr == aa) mq[i].v = 1'b0;
        if (do_pop) void'(mq.pop_front());
        if (bv && exp_br && (ba != '0) && !(a_wr && ba == aa))
            mq.push_back('{v: 1'b1, addr: ba, data: bd});

        @(posedge clk);
        #1;
        check("wb_regwrite", 64'(wb_regwrite), 64'(m_we));
        check("wb_addr", 64'(wb_addr), 64'(m_addr));
        check("wb_data", 64'(wb_data), 64'(m_data));
        if (wb_regwrite) wr_log.push_back('{addr: wb_addr, data: wb_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        model_reset();
        aready_low = 0;
        max_qc = 0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_pending_mask", 64'(pending_mask), 64'd0);
        check("rst_q_count", 64'(q_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single A write, one-cycle latency
        idle(2);
        wr_log.delete();
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        check("a_lat_regwrite", 64'(wb_regwrite), 64'd1);
        check("a_lat_addr", 64'(wb_addr), 64'd5);
        check("a_lat_data", 64'(wb_data), 64'hDEADBEEF);
        check("a_lat_mask", 64'(pending_mask), 64'd0);
        idle(1);

        // Four B pushes drain in order
        wr_log.delete();
        for (int i = 0; i < 4; i++)
            cycle(1'b0, '0, '0, 1'b1, ADDR_W'(7 + i), 32'hB000_0000 + i);
        idle(6);
        check("b_order_count", 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            check("b_order_addr", 64'(wr_log[i].addr), 64'(7 + i));
            check("b_order_data", 64'(wr_log[i].data), 64'(32'hB000_0000 + i));
        end

        // A write kills an older queued B write to the same register
        wr_log.delete();
        cycle(1'b0, '0, '0, 1'b1, 5'd12, 32'h1111);
        cycle(1'b1, 5'd12, 32'h2222, 1'b0, '0, '0);
        check("kill_mask12", 64'(pending_mask[12]), 64'd0);
        idle(4);
        check("kill_count", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) check("kill_data", 64'(wr_log[0].data), 64'h2222);

        // Starvation: continuous A traffic, one queued B entry
        wr_log.delete();
        aready_low = 0;
        cycle(1'b1, 5'd3, $urandom, 1'b1, 5'd20, 32'h2020);
        for (int i = 0; i < 12; i++) cycle(1'b1, 5'd3, $urandom, 1'b0, '0, '0);
        check("starve_block_cycles", 64'(aready_low), 64'd1);
        begin
            int n20 = 0;
            foreach (wr_log[i]) if (wr_log[i].addr == 5'd20) n20++;
            check("starve_b_written", 64'(n20), 64'd1);
        end
        idle(2);

        // Fill the queue, then zero-address requests
        wr_log.delete();
        max_qc = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'd2, $urandom, 1'b1, ADDR_W'(21 + i), $urandom);
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom);
        check("full_max_qcount", 64'(max_qc), 64'(QDEPTH));
        begin
            int nzero = 0;
            foreach (wr_log[i]) if (wr_log[i].addr == '0) nzero++;
            check("zero_addr_writes", 64'(nzero), 64'd0);
        end

        // Asynchronous reset mid-cycle with three entries queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd4, $urandom, 1'b1, ADDR_W'(11 + i), $urandom);
        check("pre_rst_qcount", 64'(q_count), 64'd3);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_regwrite", 64'(wb_regwrite), 64'd0);
        check("mid_rst_mask", 64'(pending_mask), 64'd0);
        check("mid_rst_qcount", 64'(q_count), 64'd0);
        check("mid_rst_addr", 64'(wb_addr), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wr_log.delete();
        idle(5);
        check("post_rst_no_writes", 64'(wr_log.size()), 64'd0);

        // Randomized traffic with a small address range to force collisions
        for (int i = 0; i < 2000; i++) begin
            logic av, bv;
            av = ($urandom_range(0, 3) != 0);
            bv = ($urandom_range(0, 2) != 0);
            cycle(av, ADDR_W'($urandom_range(0, 7)), $urandom,
                  bv, ADDR_W'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
